// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the ID stage.
// Decodes the immediate of a 32-bit RISC-V instruction, extends it to XLEN
// and queues it with a sideband tag in a DEPTH-entry FIFO. Both sides use a
// valid/ready handshake. FLUSH drops every queued entry (branch mispredict).
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          synchronous, active-low reset
//   IN_VALID       upstream offers an instruction
//   IN_READY       FIFO has room (count < DEPTH), independent of OUT_READY
//   IN_INSTRUCTION raw instruction word
//   IN_SELECT      immediate format: U J I B S zimm shamt none
//   IN_TAG         sideband carried alongside the immediate
//   FLUSH          discard all queued entries, ignore this cycle's push/pop
//   OUT_VALID      head entry is valid
//   OUT_READY      downstream consumes the head
//   OUT_IMMEDIATE  decoded immediate of the head entry
//   OUT_TAG        tag of the head entry
//   OUT_COUNT      number of occupied entries
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter int TAG_WIDTH = 5
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [31:0]            IN_INSTRUCTION,
    input  logic [2:0]             IN_SELECT,
    input  logic [TAG_WIDTH-1:0]   IN_TAG,
    input  logic                   FLUSH,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [XLEN-1:0]        OUT_IMMEDIATE,
    output logic [TAG_WIDTH-1:0]   OUT_TAG,
    output logic [$clog2(DEPTH):0] OUT_COUNT
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]           inst;
    logic [31:0]           imm32;
    logic [XLEN-1:0]       imm_ext;

    logic [XLEN-1:0]       mem_imm [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;

    assign inst = IN_INSTRUCTION;

    // Every format is first built as a 32-bit value whose bit 31 is the
    // extension bit; zero-extended formats leave bit 31 clear, so one
    // sign-extension to XLEN serves all of them. An unknown select falls
    // through to the default and yields 0 instead of X.
    always_comb begin
        imm32 = '0;
        case (IN_SELECT)
            3'b000:  imm32 = {inst[31:12], 12'b0};
            3'b001:  imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            3'b010:  imm32 = {{20{inst[31]}}, inst[31:20]};
            3'b011:  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                              inst[11:8], 1'b0};
            3'b100:  imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'b101:  imm32 = {27'b0, inst[19:15]};
            3'b110: begin
                if (XLEN == 64) imm32 = {26'b0, inst[25:20]};
                else            imm32 = {27'b0, inst[24:20]};
            end
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        imm_ext       = {XLEN{imm32[31]}};
        imm_ext[31:0] = imm32;
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready looks only at occupancy: a full FIFO refuses input even if the
    // head is being popped in the same cycle.
    assign IN_READY      = (count < CW'(DEPTH));
    assign OUT_VALID     = (count != '0);
    assign OUT_COUNT     = count;
    assign OUT_IMMEDIATE = mem_imm[rd_ptr];
    assign OUT_TAG       = mem_tag[rd_ptr];

    assign push = IN_VALID & IN_READY;
    assign pop  = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_tag[i] <= '0;
            end
        end else if (FLUSH) begin
            // Storage keeps stale data; only the bookkeeping is cleared.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= imm_ext;
                mem_tag[wr_ptr] <= IN_TAG;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share the same
// stimulus. Expected immediates come from the stimulus table, are queued when
// a push is seen and compared against the head while it is valid.
module tb_imm_gen_pipe;

    localparam int DEPTH = 2;
    localparam int TW    = 5;

    typedef struct packed {
        logic [63:0]   imm;
        logic [TW-1:0] tag;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_inst;
    logic [2:0]    in_sel;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_ready;
    logic [63:0]   exp32_in;
    logic [63:0]   exp64_in;

    logic          in_ready32, out_valid32, in_ready64, out_valid64;
    logic [31:0]   out_imm32;
    logic [63:0]   out_imm64;
    logic [TW-1:0] out_tag32, out_tag64;
    logic [1:0]    out_count32, out_count64;

    entry_t        q32[$];
    entry_t        q64[$];
    bit            mon_on = 1'b0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut32 (
        .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready32),
        .IN_INSTRUCTION(in_inst), .IN_SELECT(in_sel), .IN_TAG(in_tag),
        .FLUSH(flush), .OUT_VALID(out_valid32), .OUT_READY(out_ready),
        .OUT_IMMEDIATE(out_imm32), .OUT_TAG(out_tag32), .OUT_COUNT(out_count32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut64 (
        .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready64),
        .IN_INSTRUCTION(in_inst), .IN_SELECT(in_sel), .IN_TAG(in_tag),
        .FLUSH(flush), .OUT_VALID(out_valid64), .OUT_READY(out_ready),
        .OUT_IMMEDIATE(out_imm64), .OUT_TAG(out_tag64), .OUT_COUNT(out_count64)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Occupancy model + head compare, then scoreboard update for the coming edge.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("count32", 64'(out_count32), 64'(q32.size()));
            chk("count64", 64'(out_count64), 64'(q64.size()));
            chk("valid32", 64'(out_valid32), 64'(q32.size() != 0));
            chk("valid64", 64'(out_valid64), 64'(q64.size() != 0));
            chk("ready32", 64'(in_ready32), 64'(q32.size() < DEPTH));
            chk("ready64", 64'(in_ready64), 64'(q64.size() < DEPTH));
            if (q32.size() > 0) begin
                chk("imm32", 64'(out_imm32), q32[0].imm);
                chk("tag32", 64'(out_tag32), 64'(q32[0].tag));
            end
            if (q64.size() > 0) begin
                chk("imm64", out_imm64, q64[0].imm);
                chk("tag64", 64'(out_tag64), 64'(q64[0].tag));
            end
            if (!rst_n || flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (out_valid32 && out_ready && q32.size() > 0) void'(q32.pop_front());
                if (out_valid64 && out_ready && q64.size() > 0) void'(q64.pop_front());
                if (in_valid && in_ready32) q32.push_back('{imm: exp32_in, tag: in_tag});
                if (in_valid && in_ready64) q64.push_back('{imm: exp64_in, tag: in_tag});
            end
        end
    end

    task automatic drive(input logic [31:0] inst, input logic [2:0] sel, input logic [TW-1:0] tag,
                         input logic [63:0] e32, input logic [63:0] e64);
        in_valid = 1'b1;
        in_inst  = inst;
        in_sel   = sel;
        in_tag   = tag;
        exp32_in = e32;
        exp64_in = e64;
    endtask

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready32;
            @(posedge clk);
            #1;
        end
        chk("accept", 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] inst, input logic [2:0] sel, input logic [TW-1:0] tag,
                        input logic [63:0] e32, input logic [63:0] e64);
        drive(inst, sel, tag, e32, e64);
        wait_accept();
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (q32.size() != 0 || q64.size() != 0); n++) @(posedge clk);
        #1;
        chk("drained", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, 64'(out_valid32 | out_valid64), 64'd0);
        chk({name, "_ready"}, 64'(in_ready32 & in_ready64), 64'd1);
        chk({name, "_count"}, 64'(out_count32 | out_count64), 64'd0);
        chk({name, "_imm32"}, 64'(out_imm32), 64'd0);
        chk({name, "_imm64"}, out_imm64, 64'd0);
        chk({name, "_tag"}, 64'(out_tag32 | out_tag64), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_sel = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1; exp32_in = '0; exp64_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Each format, spaced pushes with OUT_READY=1.
        send({20'h53a4c, 5'd3, 7'h37}, 3'b000, 5'd1, 64'h53a4c000, 64'h0000000053a4c000);
        send({1'b1, 10'b1011010111, 1'b0, 8'b11100011, 5'd1, 7'h6f}, 3'b001, 5'd2,
             64'hfffe35ae, 64'hfffffffffffe35ae);
        send({12'hfe8, 5'd2, 3'b000, 5'd1, 7'h13}, 3'b010, 5'd3,
             64'hffffffe8, 64'hffffffffffffffe8);
        send({1'b1, 6'b001010, 5'd2, 5'd1, 3'b000, 4'b1101, 1'b1, 7'h63}, 3'b011, 5'd4,
             64'hfffff95a, 64'hfffffffffffff95a);
        send({7'b1001010, 5'd2, 5'd1, 3'b010, 5'b01010, 7'h23}, 3'b100, 5'd5,
             64'hfffff94a, 64'hfffffffffffff94a);
        send(32'hdeadbeef, 3'b111, 5'd6, 64'd0, 64'd0);
        send({12'hfff, 5'b10110, 3'b001, 5'd1, 7'h73}, 3'b101, 5'd7, 64'h16, 64'h16);
        send({7'b0000001, 5'h1f, 5'd1, 3'b001, 5'd1, 7'h13}, 3'b110, 5'd8, 64'h1f, 64'h3f);
        send({20'h80000, 5'd3, 7'h37}, 3'b000, 5'd9, 64'h80000000, 64'hffffffff80000000);
        send(32'h0000007f, 3'bxxx, 5'd10, 64'd0, 64'd0);
        drain();

        // Backpressure: fill, hold tag 3 upstream, then drain in order.
        out_ready = 1'b0;
        send({12'h001, 20'h0}, 3'b010, 5'd1, 64'h1, 64'h1);
        send({12'h002, 20'h0}, 3'b010, 5'd2, 64'h2, 64'h2);
        drive({12'h003, 20'h0}, 3'b010, 5'd3, 64'h3, 64'h3);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready32), 64'd0);
            chk("bp_head_tag", 64'(out_tag32), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Flush while full with IN_VALID held, then with a real push at count 1.
        out_ready = 1'b0;
        send({12'h011, 20'h0}, 3'b010, 5'd11, 64'h11, 64'h11);
        send({12'h012, 20'h0}, 3'b010, 5'd12, 64'h12, 64'h12);
        drive({12'h013, 20'h0}, 3'b010, 5'd13, 64'h13, 64'h13);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_count", 64'(out_count32), 64'd0);
        chk("flush_ready", 64'(in_ready32), 64'd1);
        @(posedge clk); #1;
        send({12'h014, 20'h0}, 3'b010, 5'd14, 64'h14, 64'h14);
        drive({12'h015, 20'h0}, 3'b010, 5'd15, 64'h15, 64'h15);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-stream with one entry queued and OUT_READY high.
        out_ready = 1'b0;
        send({12'h021, 20'h0}, 3'b010, 5'd21, 64'h21, 64'h21);
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        send({12'h7ff, 20'h0}, 3'b010, 5'd22, 64'h7ff, 64'h7ff);
        drain();

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
